// File: rtl/decimator_if.sv
// Valid/ready sample stream carrying W-bit two's-complement fixed-point data.
// The producer drives data/valid and the consumer drives ready.
interface decimator_if #(
    parameter int W = 32
);
    logic signed [W-1:0] data;
    logic                valid;
    logic                ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/decimator.sv
// Decimate-by-M stream stage with a single output register and valid/ready flow control.
// Define DECIMATOR_AVG_EN to emit the floor-average of each M-sample group instead of its first sample.
module decimator #(
    parameter int W      = 32,
    parameter int W_FRAC = 16,
    parameter int M      = 4
) (
    input  logic        clk,
    input  logic        reset,
    decimator_if.slave  x,
    decimator_if.master y
);
    localparam int LOG2M = $clog2(M);
    localparam logic [LOG2M-1:0] LAST_PHASE = LOG2M'(M - 1);

    generate
        if (M < 2 || M > 16 || (M & (M - 1)) != 0) begin : g_bad_m
            $error("decimator: M must be a power of two in 2..16");
        end
        if (W_FRAC < 0 || W_FRAC >= W) begin : g_bad_frac
            $error("decimator: W_FRAC must lie in 0..W-1");
        end
    endgenerate

    logic [LOG2M-1:0]    phase_p0;
    logic signed [W-1:0] data_p1;
    logic                vld_p1;
    logic                accept;
    logic                emit;
    logic signed [W-1:0] result;

    // The output register refills only when empty or draining this cycle, so a stall freezes everything upstream.
    assign x.ready = !vld_p1 || y.ready;
    assign accept  = x.valid && x.ready;
    assign y.data  = data_p1;
    assign y.valid = vld_p1;

`ifdef DECIMATOR_AVG_EN
    localparam int ACC_W = W + LOG2M;

    logic signed [ACC_W-1:0] acc_p0;
    logic signed [ACC_W-1:0] sum;

    // Arithmetic shift divides by M rounding toward minus infinity; the group mean always fits in W bits.
    function automatic logic signed [W-1:0] floor_avg(input logic signed [ACC_W-1:0] s);
        return W'(s >>> LOG2M);
    endfunction

    always_comb begin
        sum = {{LOG2M{x.data[W-1]}}, x.data};
        if (phase_p0 != '0) begin
            sum = acc_p0 + {{LOG2M{x.data[W-1]}}, x.data};
        end
    end

    assign emit   = (phase_p0 == LAST_PHASE);
    assign result = floor_avg(sum);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_p0 <= '0;
        end else if (accept) begin
            acc_p0 <= sum;
        end
    end
`else
    assign emit   = (phase_p0 == '0);
    assign result = x.data;
`endif

    // stage p0 -> p1: phase advance and output register load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_p0 <= '0;
            vld_p1   <= 1'b0;
            data_p1  <= '0;
        end else begin
            if (accept) begin
                phase_p0 <= phase_p0 + LOG2M'(1);
            end
            if (accept && emit) begin
                vld_p1  <= 1'b1;
                data_p1 <= result;
            end else if (y.ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_decimator.sv
// Scoreboard bench for decimator (M=4, W=32); builds for either output mode via DECIMATOR_AVG_EN.
`timescale 1ns/1ps
module tb_decimator;
    localparam int W      = 32;
    localparam int M      = 4;
    localparam int LOG2M  = 2;
    localparam int BUDGET = 400;
`ifdef DECIMATOR_AVG_EN
    localparam bit AVG  = 1'b1;
    localparam int EMIT = M - 1;
`else
    localparam bit AVG  = 1'b0;
    localparam int EMIT = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    decimator_if #(.W(W)) x_if ();
    decimator_if #(.W(W)) y_if ();

    decimator #(.W(W), .W_FRAC(16), .M(M)) dut (
        .clk  (clk),
        .reset(reset),
        .x    (x_if),
        .y    (y_if)
    );

    always #5 clk = ~clk;

    int tests     = 0;
    int fails     = 0;
    int out_count = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;

    int m_cnt = 0;
    logic signed [W+LOG2M-1:0] m_sum;
    logic signed [W+LOG2M-1:0] m_tmp;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Monitor: flow-control rule every cycle, and pop/compare on every output transfer.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            check("x_ready_rule", 32'(x_if.ready), 32'(!y_if.valid || y_if.ready));
            if (y_if.valid && y_if.ready) begin
                out_count++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %h, expected nothing", y_if.data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("y_data", y_if.data, mon_exp);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic model_accept(input logic [W-1:0] d);
`ifdef DECIMATOR_AVG_EN
        if (m_cnt % M == 0) m_sum = '0;
        m_sum = m_sum + $signed(d);
        if (m_cnt % M == M - 1) begin
            m_tmp = m_sum >>> LOG2M;
            exp_q.push_back(m_tmp[W-1:0]);
        end
`else
        if (m_cnt % M == 0) exp_q.push_back(d);
`endif
        m_cnt++;
    endtask

    task automatic send(input logic [W-1:0] d, input bit use_model);
        bit acc = 1'b0;
        int n   = 0;
        x_if.data  = d;
        x_if.valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = x_if.ready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n >= BUDGET) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: x.ready=0 for %0d cycles, expected acceptance", n);
                return;
            end
        end
        if (use_model) model_accept(d);
    endtask

    task automatic idle();
        x_if.valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        y_if.ready = 1'b1;
        while ((exp_q.size() != 0 || y_if.valid) && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_y_valid", 32'(y_if.valid), 32'd0);
        check("async_reset_y_data", y_if.data, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_cnt = 0;
    endtask

    logic [W-1:0] vec[20] = '{
        32'h0064_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
        32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
        32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000
    };
    logic [W-1:0] vec_avg[5]  = '{32'h0019_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [W-1:0] vec_pick[5] = '{32'h0064_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [W-1:0] rst_avg[4]  = '{32'h0004_0000, 32'h0004_0000, 32'h0004_0000, 32'h0004_0000};
    logic [W-1:0] rst_pick[4] = '{32'h0004_0000, 32'h0005_0000, 32'h0006_0000, 32'h0007_0000};

    logic [W-1:0] held;
    bit rnd_done;
    int base_count;

    initial begin
        x_if.valid = 1'b0;
        x_if.data  = '0;
        y_if.ready = 1'b1;
        m_sum      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_y_valid", 32'(y_if.valid), 32'd0);
        check("reset_y_data", y_if.data, 32'd0);
        check("reset_x_ready", 32'(x_if.ready), 32'd1);
        reset = 1'b0;

        // Back-to-back stream of 0x0001_0000..0x0008_0000, one accepted per cycle.
        exp_q.push_back(AVG ? 32'h0002_8000 : 32'h0001_0000);
        exp_q.push_back(AVG ? 32'h0006_8000 : 32'h0005_0000);
        x_if.valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            x_if.data = 32'(i + 1) << 16;
            @(posedge clk);
            #1;
            check("latency_y_valid", 32'(y_if.valid), 32'((i % M) == EMIT));
        end
        idle();
        drain();

        // Boundary groups: positive, negative, floor of -1/4, full-scale extremes.
        for (int g = 0; g < 5; g++) begin
            exp_q.push_back(AVG ? vec_avg[g] : vec_pick[g]);
            for (int k = 0; k < M; k++) send(vec[g*M + k], 1'b0);
            idle();
        end
        drain();

        // Backpressure: stall the output for 10 cycles with an input waiting.
        exp_q.push_back(AVG ? 32'h000A_0000 : 32'h0004_0000);
        exp_q.push_back(AVG ? 32'h001A_0000 : 32'h0014_0000);
        y_if.ready = 1'b0;
        for (int k = 1; k <= EMIT + 1; k++) send(32'(k) * 32'h0004_0000, 1'b0);
        check("bp_y_valid", 32'(y_if.valid), 32'd1);
        held       = y_if.data;
        x_if.data  = 32'(EMIT + 2) * 32'h0004_0000;
        x_if.valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp_x_ready", 32'(x_if.ready), 32'd0);
            check("bp_y_data_stable", y_if.data, held);
            check("bp_y_valid_hold", 32'(y_if.valid), 32'd1);
        end
        y_if.ready = 1'b1;
        for (int k = EMIT + 2; k <= 8; k++) send(32'(k) * 32'h0004_0000, 1'b0);
        idle();
        drain();

        // Reset in the middle of a group discards the partial group.
        if (!AVG) exp_q.push_back(32'h0010_0000);
        exp_q.push_back(32'h0004_0000);
        send(32'h0010_0000, 1'b0);
        send(32'h0010_0000, 1'b0);
        idle();
        do_reset();
        for (int k = 0; k < M; k++) send(AVG ? rst_avg[k] : rst_pick[k], 1'b0);
        idle();
        drain();

        // Random valid/ready over 1000 samples against the golden model.
        do_reset();
        base_count = out_count;
        rnd_done   = 1'b0;
        fork
            begin
                for (int s = 0; s < 1000; s++) begin
                    send($urandom, 1'b1);
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end
                end
                idle();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    y_if.ready = ($urandom_range(0, 2) != 0);
                end
                y_if.ready = 1'b1;
            end
        join
        drain();
        check("random_output_count", 32'(out_count - base_count), 32'(1000 / M));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/decimator.md
DECIMATOR -- requirements
Module: decimator

Interface
REQ-001 Parameter W, default 32: sample width in bits, two's-complement fixed point.
REQ-002 Parameter W_FRAC, default 16: fractional bits; carried through, no rescaling.
REQ-003 Parameter M, default 4: decimation factor; power of two, 2..16; any other value SHALL raise an elaboration-time error.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 x  dstream sink  W  input stream from the upstream low-pass filter (x.data, x.valid, x.ready).
REQ-007 y  dstream source  W  decimated output stream (y.data, y.valid, y.ready).

Function
REQ-008 A transfer SHALL occur on x when x.valid && x.ready, and on y when y.valid && y.ready, both sampled at the rising edge of clk.
REQ-009 x.ready SHALL equal !y.valid || y.ready (combinational), so the output register accepts a new result only when it is empty or draining in the same cycle.
REQ-010 A phase counter (0..M-1) SHALL advance by one per accepted input and wrap from M-1 to 0; it SHALL hold when no input is accepted.
REQ-011 An accepted input at the emit phase SHALL load y.data and set y.valid on the next edge (latency 1 cycle).
REQ-012 y.valid SHALL clear on an edge where y transfers and no new result is loaded.
REQ-013 Simultaneous y transfer and new load: y.valid SHALL stay 1 and y.data SHALL take the new value, with no bubble.
REQ-014 While y.valid && !y.ready: y.data and y.valid SHALL hold, x.ready SHALL be 0, and phase and accumulator SHALL freeze; no sample is lost or duplicated.
REQ-015 With y.ready held at 1 and x.valid held at 1, the block SHALL accept one input per cycle and emit exactly one output per M inputs.
REQ-016 Inputs with x.valid=0 SHALL have no effect; x.data is ignored when not transferred.

Reset
REQ-017 While reset=1: y.valid=0, y.data=0, phase=0, accumulator=0, effective immediately (asynchronous).
REQ-018 Reset mid-group SHALL discard all partial-group state; the first accepted input after release is phase 0.
REQ-019 Reset release SHALL be synchronised by the clock edge; no transfer occurs in the cycle reset is high.

Configuration
REQ-020 Macro DECIMATOR_AVG_EN selects the output function.
REQ-021 DECIMATOR_AVG_EN defined: emit phase = M-1; output = (sum of the M accepted samples) arithmetically shifted right by log2(M), i.e. rounding toward minus infinity.
REQ-022 DECIMATOR_AVG_EN defined: the accumulator SHALL be W+log2(M) bits signed (no overflow possible), and SHALL reload (not add) on phase 0.
REQ-023 DECIMATOR_AVG_EN undefined: emit phase = 0; output = the phase-0 sample unmodified; phases 1..M-1 are discarded; no accumulator is instantiated.

Verification
REQ-024 Pick mode, M=4, y.ready=1: inputs 0x0001_0000..0x0008_0000 on consecutive cycles -> outputs 0x0001_0000 then 0x0005_0000, each one cycle after its acceptance.
REQ-025 Avg mode, M=4: inputs 0x0064_0000,0,0,0 -> single output 0x0019_0000; inputs 0xFFFF_0000 x4 -> 0xFFFF_0000.
REQ-026 Avg mode, M=4: inputs 0xFFFF_FFFF,0,0,0 -> output 0xFFFF_FFFF (floor of -1/4).
REQ-027 Backpressure: after an output becomes valid, hold y.ready=0 for 10 cycles with x.valid=1 -> y.data stable, x.ready=0 throughout; on release the full input sequence emerges with no loss or duplication versus a golden model.
REQ-028 Reset mid-group, avg mode, M=4: accept 0x0010_0000 x2, pulse reset, accept 0x0004_0000 x4 -> exactly one output, 0x0004_0000.
REQ-029 Randomised x.valid/y.ready over 1000 samples, both modes: output count = floor(inputs/M); values match the golden model; x.ready == !y.valid || y.ready every cycle.
